// File: rtl/fifo_unpack.sv
// Drains a FIFO read port one IN_W word at a time and re-emits each word as
// N = IN_W/OUT_W OUT_W-bit chunks on a valid/ready stream, with no gap between words.
module fifo_unpack #(
  parameter  int IN_W      = 32,
  parameter  int OUT_W     = 8,
  parameter  int MSB_FIRST = 0,
  localparam int N         = IN_W / OUT_W,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic [IN_W-1:0]  i_rdata,
  input  logic             i_rvalid,
  output logic             o_rready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_popped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IN_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d, sel;
  logic             full_q, full_d;
  logic             take, done;

  assign o_valid  = full_q;
  assign o_idx    = idx_q;
  assign o_last   = (idx_q == LAST_IDX);
  assign take     = i_cg & full_q & i_ready;
  assign done     = take & o_last;
  // Combinational pop so the next word lands the same edge the last chunk leaves.
  assign o_rready = i_cg & (~full_q | done);
  assign o_popped = o_rready & i_rvalid;

  assign sel = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

  always_comb begin
    o_data = '0;
    for (int j = 0; j < N; j++) begin
      if (sel == IDX_W'(j)) o_data = word_q[j*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (o_popped) begin
      word_d = i_rdata;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (done) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else if (take) begin
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: doc/fifo_unpack.md
Name: fifo_unpack

Overview:
- Single-clock reader for the read port of a FIFO (o_rdata/o_rvalid/i_rready side).
- Pops one IN_W-bit word at a time and emits it as IN_W/OUT_W consecutive OUT_W-bit chunks on a valid/ready stream.
- Typical use: drain a wide cdc FIFO into a byte-wide consumer such as a UART/USB transmit path.
- Full throughput: a new word is popped in the same cycle its predecessor's last chunk is accepted.

Parameters:
- IN_W, 32: input word width. Must be a multiple of OUT_W.
- OUT_W, 8: output chunk width, >= 1.
- MSB_FIRST, 0: 0 emits the least-significant chunk first; 1 emits the most-significant chunk first.
- Derived: N = IN_W/OUT_W (>= 1); IDX_W = max(1, $clog2(N)).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_cg  input  1  clock-gate enable. When 0, no state changes.
- i_rdata  input  IN_W  FIFO read data.
- i_rvalid  input  1  FIFO not-empty.
- o_rready  output  1  pop request to FIFO.
- o_data  output  OUT_W  current chunk.
- o_valid  output  1  chunk valid.
- i_ready  input  1  downstream accepts chunk.
- o_idx  output  IDX_W  emission index of current chunk, 0..N-1.
- o_last  output  1  current chunk is the final chunk of its word.
- o_popped  output  1  pulse: word popped this cycle.

Behaviour:
- State registers:
  - word_q [IN_W]
  - idx_q [IDX_W]
  - full_q [1]
- Reset (async assert, any time, including mid-word): word_q=0, idx_q=0, full_q=0. Any partially emitted word is discarded.
- Output values out of reset: o_valid=0, o_data=0, o_idx=0, o_last=(N==1), o_popped=0, o_rready=i_cg.
- Output assignments:
  - o_valid = full_q
  - o_idx = idx_q
  - o_last = (idx_q == N-1)
  - o_data = chunk k of word_q, where k = idx_q if MSB_FIRST==0, else N-1-idx_q; chunk k = word_q[k*OUT_W +: OUT_W].
- Definitions:
  - take = i_cg && full_q && i_ready (chunk accepted).
  - done = take && o_last.
  - o_rready = i_cg && (!full_q || done). Combinational, so no bubble between words.
  - o_popped = o_rready && i_rvalid.
- State machine (implicit in full_q):
  - EMPTY (full_q=0): on o_popped, word_q<=i_rdata, idx_q<=0, full_q<=1; go to BUSY.
  - BUSY (full_q=1):
    - take && !o_last: idx_q<=idx_q+1; word_q held.
    - done && i_rvalid: load new word, idx_q<=0, stay BUSY.
    - done && !i_rvalid: full_q<=0, idx_q<=0; go to EMPTY.
    - no take: hold everything. o_data/o_valid stay stable while stalled (valid/ready rule).
- Latency: first chunk is visible the cycle after the pop. A steady stream gives 1 chunk/cycle with no gap at word boundaries.
- idx_q never exceeds N-1; wrap to 0 happens only on done.
- N==1: acts as a single registered pipeline stage; o_last is constant 1.
- i_cg=0:
  - o_rready=0 and take is ignored, so no pop or chunk is consumed.
  - o_valid/o_data remain driven. Downstream must not count a transfer while i_cg=0.
- i_rdata is sampled only when o_popped=1. Its value is don't-care otherwise.

Test Plan:
- Reset then 0x44332211 with i_rvalid=1, i_ready=1, MSB_FIRST=0 → o_popped pulses once. Next 4 cycles o_data = 0x11, 0x22, 0x33, 0x44; o_idx = 0..3; o_last only with 0x44.
- Same word with MSB_FIRST=1 → o_data order 0x44, 0x33, 0x22, 0x11.
- Back-to-back words 0xA3A2A1A0 and 0xB3B2B1B0, i_ready=1 → 8 consecutive valid cycles, no bubble. Second o_popped coincides with the 0xA3 acceptance.
- i_ready low for 3 cycles on the 0x22 chunk → o_data stays 0x22 and o_idx stays 1 for 3 cycles; no pop occurs; emission then resumes with 0x33.
- Assert i_rst asynchronously after 0x22 is accepted → o_valid drops immediately. After release, the next popped word starts at chunk 0 and the remnant 0x33/0x44 never appears.
- i_cg=0 for 2 cycles with i_ready=1 mid-word, then a single word ending while the FIFO is empty → no idx advance and no pop while gated. After the last chunk, o_valid=0 and o_rready=1.
